usr_shift_reg: RTL and testbench
================================

# usr_shift_reg

Parametrised universal shift register: the successor to the fixed 8-bit left/right shifter. It adds configurable width, four shift/rotate operations, parallel load, serial in/out, single-step shifting and a counted burst mode with busy/done handshake. It is used wherever a datapath needs a loadable shifter driven by a small controller, such as a serialiser, LFSR seed loader or bit-rotate stage.

## Interface
- WIDTH, 8, register width in bits (≥2)
- CNT_W, 4, width of the burst shift-count input
- RESET_VAL, {WIDTH{1'b0}}, value of q after reset
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset; synchronous, active-high
- op  in  2  operation: 00 shift left, 01 shift right, 10 rotate left, 11 rotate right
- sin  in  1  serial input bit used by shift ops
- load  in  1  parallel-load request
- din  in  WIDTH  parallel-load data
- step  in  1  single-shift request
- start  in  1  burst request
- count  in  CNT_W  number of shifts in a burst
- q  out  WIDTH  register contents (registered)
- sout  out  1  bit expelled by the most recent shift or rotate (registered)
- busy  out  1  high while a burst is running
- done  out  1  one-cycle pulse marking the end of a burst

## Operation
- Shift left: q <= {q[WIDTH-2:0], sin}; sout <= q[WIDTH-1].
- Shift right (logical): q <= {sin, q[WIDTH-1:1]}; sout <= q[0].
- Rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}; sout <= q[WIDTH-1]. sin is ignored.
- Rotate right: q <= {q[0], q[WIDTH-1:1]}; sout <= q[0]. sin is ignored.
- FSM states:
  - IDLE: request priority is rst > load > start > step.
    - load: q <= din; sout unchanged.
    - start with count==0: no shift; done pulses in the next cycle; remain in IDLE.
    - start with count>0: latch op and count into op_r/rem; go to RUN; no shift on this edge.
    - step: perform one shift using the live op.
  - RUN: on every edge, shift once using op_r and rem decrements. sin is sampled live each cycle, which supports serial streaming.
    - When rem reaches 1, the edge performs the final shift, the FSM returns to IDLE and done is set.
    - load, start and step are ignored while in RUN (no queuing).
- A count larger than WIDTH is legal. The extra shifts continue normally, so rotates wrap and shifts flush with sin.
- op changes during RUN have no effect.

## Timing
- Reset values: q=RESET_VAL, sout=0, busy=0, done=0, state=IDLE.
- Load and step: result visible in q one cycle after the request edge.
- Burst of k>0 shifts, with start sampled at edge E0:
  - busy is high after E0 through Ek (k cycles).
  - Shifts occur at E1..Ek.
  - done is high for exactly one cycle after Ek, while busy is already 0.
  - A new start is accepted in the same cycle that done is high.
- count==0: done is high for one cycle after E0; busy stays 0.
- rst during RUN: the next edge forces all reset values. No done is produced and the partial shift result is discarded.
- load, start and step asserted in the same IDLE cycle: load wins and the others are dropped.

## Configuration
- USR_ARITH_SHIFT_EN defined: op=01 is an arithmetic right shift, q <= {q[WIDTH-1], q[WIDTH-1:1]}. sin is ignored and sout <= q[0].
- USR_ARITH_SHIFT_EN undefined: op=01 is a logical right shift with sin filling the MSB, as described above.
- All other ops are identical in both builds.

## Test plan
- Reset: assert rst for 2 cycles with WIDTH=8 and RESET_VAL=0 -> q=0x00, sout=0, busy=0, done=0.
- Load then step: load din=0xA5, then step with op=00 and sin=1 -> q=0x4B, sout=1.
- Rotate burst: load 0x81, then start with op=10 and count=3 -> busy high for 3 cycles, q=0x0C, sout=0, done high for 1 cycle after the third shift; load asserted during busy leaves q unaffected.
- Right shift: load 0x80, then start with op=01, count=2, sin=0 -> q=0x20 with USR_ARITH_SHIFT_EN undefined, q=0xE0 with it defined.
- Zero count: start with count=0 -> done pulses one cycle later, busy never rises, q unchanged.
- Reset mid-burst: start with op=00 and count=5, assert rst after 2 shifts -> q=0x00, busy=0, no done pulse; a subsequent step works normally.

Source files
------------

// File: rtl/usr_shift_reg.sv
// Universal shift register: parallel load, single-step shift/rotate and counted bursts.
// Build option USR_ARITH_SHIFT_EN turns op=01 into an arithmetic right shift.
module usr_shift_reg #(
    parameter int unsigned           WIDTH     = 8,
    parameter int unsigned           CNT_W     = 4,
    parameter logic [WIDTH-1:0]      RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       op,
    input  logic             sin,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             step,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               sout_q, sout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [1:0]         op_r_q, op_r_d;
    logic [CNT_W-1:0]   rem_q, rem_d;

    // Returns {expelled bit, next register value}.
    function automatic logic [WIDTH:0] shift_op(input logic [WIDTH-1:0] v,
                                                input logic [1:0]       o,
                                                input logic             s);
        case (o)
            2'b00:   return {v[WIDTH-1], v[WIDTH-2:0], s};
`ifdef USR_ARITH_SHIFT_EN
            2'b01:   return {v[0], v[WIDTH-1], v[WIDTH-1:1]};
`else
            2'b01:   return {v[0], s, v[WIDTH-1:1]};
`endif
            2'b10:   return {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
            default: return {v[0], v[0], v[WIDTH-1:1]};
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        sout_d  = sout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        op_r_d  = op_r_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    q_d = din;
                end else if (start) begin
                    if (count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        op_r_d  = op;
                        rem_d   = count;
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end
                end else if (step) begin
                    {sout_d, q_d} = shift_op(q_q, op, sin);
                end
            end
            default: begin
                // Requests are ignored here; sin stays live so bursts can stream serial data.
                {sout_d, q_d} = shift_op(q_q, op_r_q, sin);
                rem_d = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= RESET_VAL;
            sout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            op_r_q  <= 2'b00;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            sout_q  <= sout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            op_r_q  <= op_r_d;
            rem_q   <= rem_d;
        end
    end

    assign q    = q_q;
    assign sout = sout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_usr_shift_reg.sv
// Directed bench for usr_shift_reg: per-cycle vector table plus burst corner sequences.
module tb_usr_shift_reg;

    logic       clk = 1'b0;
    logic       rst, load, step, start, sin;
    logic [1:0] op;
    logic [7:0] din;
    logic [3:0] count;
    logic [7:0] q;
    logic       sout, busy, done;

    int n_pass = 0;
    int n_total = 0;

    usr_shift_reg dut (
        .clk(clk), .rst(rst), .op(op), .sin(sin), .load(load), .din(din),
        .step(step), .start(start), .count(count),
        .q(q), .sout(sout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, load, step, start, sin;
        logic [1:0] op;
        logic [7:0] din;
        logic [3:0] count;
        logic [7:0] eq;
        logic       esout, ebusy, edone;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got 0x%02h expected 0x%02h", name, idx, act, exp);
    endtask

    task automatic check_all(input string name, input int idx, input logic [7:0] eq,
                             input logic es, input logic eb, input logic ed);
        check({name, ".q"}, idx, q, eq);
        check({name, ".sout"}, idx, {7'd0, sout}, {7'd0, es});
        check({name, ".busy"}, idx, {7'd0, busy}, {7'd0, eb});
        check({name, ".done"}, idx, {7'd0, done}, {7'd0, ed});
    endtask

    task automatic idle_inputs();
        rst = 0; load = 0; step = 0; start = 0; sin = 0; op = 2'b00; din = 8'h00; count = 4'd0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic r, logic l, logic st, logic sa, logic si, logic [1:0] o,
                                logic [7:0] d, logic [3:0] c, logic [7:0] eq,
                                logic es, logic eb, logic ed);
        vec_t v;
        v.rst = r; v.load = l; v.step = st; v.start = sa; v.sin = si; v.op = o;
        v.din = d; v.count = c; v.eq = eq; v.esout = es; v.ebusy = eb; v.edone = ed;
        return v;
    endfunction

    logic [7:0] exp_rs;

    initial begin
        //              rst ld stp sta sin op     din    cnt   q      so bsy dn
        vecs[0]  = mk(1, 0, 0, 0, 0, 2'b00, 8'h00, 4'd0, 8'h00, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 0, 2'b00, 8'h00, 4'd0, 8'h00, 0, 0, 0);
        vecs[2]  = mk(0, 1, 0, 0, 0, 2'b00, 8'hA5, 4'd0, 8'hA5, 0, 0, 0);
        vecs[3]  = mk(0, 0, 1, 0, 1, 2'b00, 8'h00, 4'd0, 8'h4B, 1, 0, 0);
        vecs[4]  = mk(0, 1, 0, 0, 0, 2'b00, 8'h81, 4'd0, 8'h81, 1, 0, 0);
        vecs[5]  = mk(0, 0, 0, 1, 0, 2'b10, 8'h00, 4'd3, 8'h81, 1, 1, 0);
        vecs[6]  = mk(0, 1, 1, 1, 1, 2'b11, 8'hFF, 4'd7, 8'h03, 1, 1, 0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 2'b00, 8'h00, 4'd0, 8'h06, 0, 1, 0);
        vecs[8]  = mk(0, 0, 0, 0, 0, 2'b00, 8'h00, 4'd0, 8'h0C, 0, 0, 1);
        vecs[9]  = mk(0, 0, 0, 0, 0, 2'b00, 8'h00, 4'd0, 8'h0C, 0, 0, 0);
        vecs[10] = mk(0, 1, 1, 1, 0, 2'b00, 8'h3C, 4'd2, 8'h3C, 0, 0, 0);
        vecs[11] = mk(0, 0, 1, 0, 0, 2'b11, 8'h00, 4'd0, 8'h1E, 0, 0, 0);
        vecs[12] = mk(0, 0, 1, 0, 1, 2'b10, 8'h00, 4'd0, 8'h3C, 0, 0, 0);

        idle_inputs();
        for (int i = 0; i < 13; i++) begin
            rst = vecs[i].rst; load = vecs[i].load; step = vecs[i].step; start = vecs[i].start;
            sin = vecs[i].sin; op = vecs[i].op; din = vecs[i].din; count = vecs[i].count;
            cyc();
            check_all("vec", i, vecs[i].eq, vecs[i].esout, vecs[i].ebusy, vecs[i].edone);
        end

        // Right shift burst of 2, then a new start accepted while done is high.
`ifdef USR_ARITH_SHIFT_EN
        exp_rs = 8'hE0;
`else
        exp_rs = 8'h20;
`endif
        idle_inputs(); load = 1; din = 8'h80; cyc();
        idle_inputs(); start = 1; op = 2'b01; count = 4'd2; cyc();
        idle_inputs(); cyc();
        idle_inputs(); cyc();
        check_all("rshift", 0, exp_rs, 0, 0, 1);
        start = 1; op = 2'b10; count = 4'd1; cyc();
        check_all("restart", 0, exp_rs, 0, 1, 0);
        idle_inputs(); cyc();
        check_all("restart", 1, {exp_rs[6:0], exp_rs[7]}, exp_rs[7], 0, 1);

        // Zero count: done only, no busy, q unchanged.
        idle_inputs(); load = 1; din = 8'h5A; cyc();
        idle_inputs(); start = 1; op = 2'b00; count = 4'd0; cyc();
        check_all("zero", 0, 8'h5A, exp_rs[7], 0, 1);
        idle_inputs(); cyc();
        check_all("zero", 1, 8'h5A, exp_rs[7], 0, 0);

        // Count larger than WIDTH: nine left rotates of 0x01 wrap to 0x02.
        idle_inputs(); load = 1; din = 8'h01; cyc();
        idle_inputs(); start = 1; op = 2'b10; count = 4'd9; cyc();
        idle_inputs();
        for (int i = 0; i < 8; i++) cyc();
        check_all("long", 0, 8'h01, 1, 1, 0);
        cyc();
        check_all("long", 1, 8'h02, 0, 0, 1);

        // Reset mid-burst discards the partial result and suppresses done.
        idle_inputs(); load = 1; din = 8'hFF; cyc();
        idle_inputs(); start = 1; op = 2'b00; count = 4'd5; cyc();
        idle_inputs(); cyc(); cyc();
        check_all("midrst", 0, 8'hFC, 1, 1, 0);
        rst = 1; cyc();
        check_all("midrst", 1, 8'h00, 0, 0, 0);
        idle_inputs(); cyc();
        check_all("midrst", 2, 8'h00, 0, 0, 0);
        step = 1; op = 2'b00; sin = 1; cyc();
        check_all("midrst", 3, 8'h01, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
